spi_slave_transmitter: RTL

SPI_SLAVE_TRANSMITTER -- requirements
Module: spi_slave_transmitter

---
 rtl/spi_slave_transmitter_if.sv | 25 ++
 rtl/spi_slave_transmitter.sv | 113 +++++++++++
 2 files changed

// File: rtl/spi_slave_transmitter_if.sv
// Bus bundle for the SPI slave response transmitter: SPI pins, response
// request/operands from the host logic, and status back to it.
interface spi_slave_transmitter_if;
  logic        io_SpiClk;
  logic        io_CS;
  logic        io_Start;
  logic [1:0]  io_ResponseType;
  logic [7:0]  io_R1;
  logic [31:0] io_Payload;
  logic [3:0]  io_NcrBytes;
  logic        io_DO;
  logic        io_Busy;
  logic        io_Done;
  logic        io_Aborted;

  modport slave (
    input  io_SpiClk, io_CS, io_Start, io_ResponseType, io_R1, io_Payload, io_NcrBytes,
    output io_DO, io_Busy, io_Done, io_Aborted
  );

  modport master (
    output io_SpiClk, io_CS, io_Start, io_ResponseType, io_R1, io_Payload, io_NcrBytes,
    input  io_DO, io_Busy, io_Done, io_Aborted
  );
endinterface

// File: rtl/spi_slave_transmitter.sv
// SPI mode-0 slave that sends 0xFF filler bytes followed by an R1 or R3/R7
// response, shifting on SCK falling edges detected in the system clock domain.
//
// state | meaning
// IDLE  | waiting for a start request with CS low; MISO held high
// FILL  | clocking out 0xFF filler bits, one per SCK fall
// SEND  | clocking out the response MSB first, one bit per SCK fall
module spi_slave_transmitter (
  input  logic                          clock,
  input  logic                          reset,
  spi_slave_transmitter_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SEND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        prev_sck_q, prev_sck_d;
  logic [6:0]  fill_cnt_q, fill_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic        fall;
  logic [3:0]  ncr_eff;
  logic [6:0]  fill_load;
  logic [5:0]  bit_load;

  assign fall      = prev_sck_q & ~bus.io_SpiClk;
  assign ncr_eff   = (bus.io_NcrBytes == 4'd0) ? 4'd1 : bus.io_NcrBytes;
  assign fill_load = {ncr_eff, 3'b000};
  assign bit_load  = (bus.io_ResponseType == 2'd1) ? 6'd40 : 6'd8;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prev_sck_q <= 1'b0;
      fill_cnt_q <= 7'd0;
      bit_cnt_q  <= 6'd0;
      shift_q    <= 40'd0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_sck_q <= prev_sck_d;
      fill_cnt_q <= fill_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_sck_d = bus.io_SpiClk;
    fill_cnt_d = fill_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A fall in the accept cycle is deliberately not counted.
        if (bus.io_Start && !bus.io_CS) begin
          shift_d    = {bus.io_R1, bus.io_Payload};
          bit_cnt_d  = bit_load;
          fill_cnt_d = fill_load;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.io_CS) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (fall && fill_cnt_q != 7'd0) begin
          fill_cnt_d = fill_cnt_q - 7'd1;
          if (fill_cnt_q == 7'd1) begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (bus.io_CS) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (fall && bit_cnt_q != 6'd0) begin
          shift_d   = {shift_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q - 6'd1;
          if (bit_cnt_q == 6'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.io_DO      = (state_q == S_SEND) ? shift_q[39] : 1'b1;
    bus.io_Busy    = (state_q != S_IDLE);
    bus.io_Done    = done_q;
    bus.io_Aborted = aborted_q;
  end

endmodule
